// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the round-robin ALU arbiter.
// Optional build macro: ALU_ARB_FLAGS_EN (adds rsp_zero / rsp_neg flags).
package alu_arb_pkg;

    localparam int   ALU_W      = 16;
    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } alu_arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response/ALU bundle between the requesters, the arbiter and the ALU.
// slave: arbiter side. master: requesters + ALU side.
// Optional build macro: ALU_ARB_FLAGS_EN (adds rsp_zero / rsp_neg).
interface alu_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = alu_arb_pkg::ALU_W
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_sub;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [W-1:0]      rsp_result;
`ifdef ALU_ARB_FLAGS_EN
    logic              rsp_zero;
    logic              rsp_neg;
`endif

    logic              alu_in;
    logic [W-1:0]      alu_operand1;
    logic [W-1:0]      alu_operand2;
    logic              alu_operation;
    logic [W-1:0]      alu_result;

`ifdef ALU_ARB_FLAGS_EN
    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_neg,
        output alu_in, alu_operand1, alu_operand2, alu_operation
    );
    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_neg,
        input  alu_in, alu_operand1, alu_operand2, alu_operation
    );
`else
    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_id, rsp_result,
        output alu_in, alu_operand1, alu_operand2, alu_operation
    );
    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_id, rsp_result,
        input  alu_in, alu_operand1, alu_operand2, alu_operation
    );
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr,
// wrapping modulo NREQ. No state; the caller owns and advances ptr.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    // Walk the requesters starting at ptr; the first hit wins.
    always_comb begin
        logic [IW:0] pos;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        pos     = '0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr + k stays below 2*NREQ, so one conditional subtract is a full modulo
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(NREQ))
                pos = pos - (IW+1)'(NREQ);
            if (!any && req[pos[IW-1:0]]) begin
                any               = 1'b1;
                gnt[pos[IW-1:0]]  = 1'b1;
                gnt_idx           = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one add/sub ALU between NREQ requesters.
// One op per transaction: accept -> strobe ALU -> capture result after a
// fixed one-cycle latency -> hold response until rsp_ready.
// Optional build macro: ALU_ARB_FLAGS_EN (registered rsp_zero / rsp_neg).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = ALU_W
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    localparam int IW = $clog2(NREQ);

    alu_arb_state_t  state;
    logic [IW-1:0]   rr_ptr;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            any;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // Grant is only offered while idle; held low throughout reset.
    assign bus.req_ready = (state == IDLE && !rst) ? gnt : '0;

    // Transaction FSM with registered ALU and response outputs.
    // The ALU done pulse is deliberately ignored: completion is by fixed latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            bus.alu_in        <= 1'b0;
            bus.alu_operand1  <= '0;
            bus.alu_operand2  <= '0;
            bus.alu_operation <= ALU_OP_ADD;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_id        <= '0;
            bus.rsp_result    <= '0;
`ifdef ALU_ARB_FLAGS_EN
            bus.rsp_zero      <= 1'b0;
            bus.rsp_neg       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // any implies req_valid[g] & req_ready[g] for the granted g
                    if (any) begin
                        bus.alu_operand1  <= bus.req_b[int'(gnt_idx)*W +: W];
                        bus.alu_operand2  <= bus.req_a[int'(gnt_idx)*W +: W];
                        bus.alu_operation <= bus.req_sub[gnt_idx];
                        bus.rsp_id        <= gnt_idx;
                        rr_ptr            <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + IW'(1);
                        bus.alu_in        <= 1'b1;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.alu_in <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    bus.rsp_result <= bus.alu_result;
`ifdef ALU_ARB_FLAGS_EN
                    bus.rsp_zero   <= (bus.alu_result == '0);
                    bus.rsp_neg    <= bus.alu_result[W-1];
`endif
                    bus.rsp_valid  <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table for single ops, plus
// hand-written contention, backpressure and mid-op reset sequences.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.NREQ(NREQ), .W(W)) bus();

    alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ALU model: strobe captures, result valid the following cycle
    logic [W-1:0] alu_q = '0;
    always @(posedge clk)
        if (bus.alu_in)
            alu_q <= (bus.alu_operation == ALU_OP_SUB) ? bus.alu_operand2 - bus.alu_operand1
                                                       : bus.alu_operand2 + bus.alu_operand1;
    assign bus.alu_result = alu_q;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Poll (bounded) until a grant is offered, then compare it.
    task automatic wait_grant(input logic [3:0] exp_gnt, input string name);
        int n;
        n = 0;
        #1;
        while (bus.req_ready == '0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, 32'(bus.req_ready), 32'(exp_gnt));
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  sub;
        logic [1:0]  id;
        logic [15:0] res;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int          order [$];
        int          exp_o [5];
        int          n;
        logic        ok;
        logic [15:0] ea, eb;

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sub   = '0;
        bus.rsp_ready = 1'b1;

        // rr_ptr walk: 0 ->g0-> 1 ->g2-> 3 ->g0-> 1 ->g1-> 2 ->g3-> 0 ->g3-> 0
        vecs[0] = '{valid:4'b0001, a:{48'h0, 16'h0003}, b:{48'h0, 16'h0004},
                    sub:4'b0000, id:2'd0, res:16'h0007};
        vecs[1] = '{valid:4'b0100, a:64'h0, b:{16'h0, 16'h0001, 32'h0},
                    sub:4'b0100, id:2'd2, res:16'hFFFF};
        vecs[2] = '{valid:4'b0011, a:{32'h0, 16'h8000, 16'h1234}, b:{32'h0, 16'h8000, 16'h1234},
                    sub:4'b0001, id:2'd0, res:16'h0000};
        vecs[3] = '{valid:4'b0011, a:{32'h0, 16'h8000, 16'h1234}, b:{32'h0, 16'h8000, 16'h1234},
                    sub:4'b0001, id:2'd1, res:16'h0000};
        vecs[4] = '{valid:4'b1001, a:{16'h0010, 32'h0, 16'h1234}, b:{16'h0020, 32'h0, 16'h1234},
                    sub:4'b1001, id:2'd3, res:16'hFFF0};
        vecs[5] = '{valid:4'b1000, a:{16'h7FFF, 48'h0}, b:{16'h0001, 48'h0},
                    sub:4'b0000, id:2'd3, res:16'h8000};

        // ---- reset state
        @(negedge clk);
        bus.req_valid = 4'b1111;
        #1;
        chk("rst_req_ready",  32'(bus.req_ready), 32'h0);
        chk("rst_alu_in",     32'(bus.alu_in), 32'h0);
        chk("rst_rsp_valid",  32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_id",     32'(bus.rsp_id), 32'h0);
        chk("rst_rsp_result", 32'(bus.rsp_result), 32'h0);
        chk("rst_operands",   {bus.alu_operand1, bus.alu_operand2}, 32'h0);
        chk("rst_operation",  32'(bus.alu_operation), 32'h0);
`ifdef ALU_ARB_FLAGS_EN
        chk("rst_flags", {30'h0, bus.rsp_zero, bus.rsp_neg}, 32'h0);
`endif
        do_reset();

        // ---- vector table, rsp_ready held high
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.req_a     = vecs[i].a;
            bus.req_b     = vecs[i].b;
            bus.req_sub   = vecs[i].sub;
            bus.req_valid = vecs[i].valid;
            wait_grant(4'(4'b0001 << vecs[i].id), $sformatf("v%0d_grant", i));
            ea = vecs[i].a[int'(vecs[i].id)*16 +: 16];
            eb = vecs[i].b[int'(vecs[i].id)*16 +: 16];
            @(negedge clk);                       // ISSUE
            bus.req_valid = '0;
            chk($sformatf("v%0d_issue_strobe", i), 32'(bus.alu_in), 32'h1);
            chk($sformatf("v%0d_busy_ready", i),   32'(bus.req_ready), 32'h0);
            chk($sformatf("v%0d_operands", i),     {bus.alu_operand1, bus.alu_operand2}, {eb, ea});
            chk($sformatf("v%0d_operation", i),    32'(bus.alu_operation), 32'(vecs[i].sub[vecs[i].id]));
            @(negedge clk);                       // WAIT
            chk($sformatf("v%0d_wait_strobe", i),  32'(bus.alu_in), 32'h0);
            chk($sformatf("v%0d_wait_rsp", i),     32'(bus.rsp_valid), 32'h0);
            @(negedge clk);                       // RESP: cycle 3 after accept
            chk($sformatf("v%0d_rsp_valid", i),    32'(bus.rsp_valid), 32'h1);
            chk($sformatf("v%0d_rsp_id", i),       32'(bus.rsp_id), 32'(vecs[i].id));
            chk($sformatf("v%0d_rsp_result", i),   32'(bus.rsp_result), 32'(vecs[i].res));
`ifdef ALU_ARB_FLAGS_EN
            chk($sformatf("v%0d_rsp_zero", i),     32'(bus.rsp_zero), 32'(vecs[i].res == 16'h0));
            chk($sformatf("v%0d_rsp_neg", i),      32'(bus.rsp_neg), 32'(vecs[i].res[15]));
`endif
            @(negedge clk);
            chk($sformatf("v%0d_rsp_drop", i),     32'(bus.rsp_valid), 32'h0);
        end

        // ---- contention: all valid from reset, expect 0,1,2,3,0
        do_reset();
        bus.req_a     = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        bus.req_b     = '0;
        bus.req_sub   = '0;
        bus.req_valid = 4'b1111;
        n = 0;
        while (order.size() < 5 && n < 60) begin
            #1;
            for (int g = 0; g < NREQ; g++)
                if (bus.req_ready[g]) order.push_back(g);
            @(negedge clk);
            n++;
        end
        exp_o = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++)
            chk($sformatf("rr_order%0d", k), (k < order.size()) ? 32'(order[k]) : 32'd99, 32'(exp_o[k]));
        bus.req_valid = '0;

        // ---- backpressure: hold response 10 cycles, no new grant meanwhile
        do_reset();
        bus.rsp_ready = 1'b0;
        bus.req_a     = {32'h0, 16'h0005, 16'h0};
        bus.req_b     = {32'h0, 16'h0002, 16'h0};
        bus.req_sub   = 4'b0010;
        bus.req_valid = 4'b0010;
        wait_grant(4'b0010, "bp_grant");
        @(negedge clk);
        bus.req_valid = 4'b1001;
        @(negedge clk);
        @(negedge clk);
        chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 ||
                bus.rsp_result !== 16'h0003 || bus.req_ready !== 4'b0000)
                ok = 1'b0;
        end
        chk("bp_stable", 32'(ok), 32'h1);
        chk("bp_rsp_result", 32'(bus.rsp_result), 32'h3);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_rsp_drop",   32'(bus.rsp_valid), 32'h0);
        chk("bp_next_grant", 32'(bus.req_ready), 32'b1000);
        bus.req_valid = '0;

        // ---- reset during WAIT: op dropped, rr_ptr back to 0, request re-granted
        do_reset();
        bus.req_valid = 4'b0010;
        wait_grant(4'b0010, "mr_grant");
        @(negedge clk);                           // ISSUE
        @(negedge clk);                           // WAIT
        rst = 1'b1;
        #1;
        chk("mr_alu_in",    32'(bus.alu_in), 32'h0);
        chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("mr_rsp_id",    32'(bus.rsp_id), 32'h0);
        chk("mr_operands",  {bus.alu_operand1, bus.alu_operand2}, 32'h0);
        chk("mr_operation", 32'(bus.alu_operation), 32'h0);
        chk("mr_req_ready", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 4'b0101;
        #1;
        chk("mr_ptr_zero",  32'(bus.req_ready), 32'b0001);
        chk("mr_no_rsp",    32'(bus.rsp_valid), 32'h0);
        bus.req_valid = 4'b0010;
        #1;
        chk("mr_regrant",   32'(bus.req_ready), 32'b0010);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("mr_rsp_valid2",  32'(bus.rsp_valid), 32'h1);
        chk("mr_rsp_id2",     32'(bus.rsp_id), 32'h1);
        chk("mr_rsp_result2", 32'(bus.rsp_result), 32'h3);
`ifdef ALU_ARB_FLAGS_EN
        chk("mr_flags", {30'h0, bus.rsp_zero, bus.rsp_neg}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
